// File: rtl/framebuffer_fetch_requester_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | framebuffer_fetch_requester_if                                             |
// | Pixel-index input stream, fetch output stream and AXI AR/R monitor signals.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface framebuffer_fetch_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  logic                  s_addr_axis_tvalid;
  logic                  s_addr_axis_tready;
  logic                  s_addr_axis_tlast;
  logic [ADDR_WIDTH-1:0] s_addr_axis_tdest;

  logic                  m_fetch_axis_tvalid;
  logic                  m_fetch_axis_tready;
  logic                  m_fetch_axis_tlast;
  logic [ADDR_WIDTH-1:0] m_fetch_axis_tdest;

  logic [ID_WIDTH-1:0]   m_mem_axi_arid;
  logic [ADDR_WIDTH-1:0] m_mem_axi_araddr;
  logic [7:0]            m_mem_axi_arlen;
  logic [2:0]            m_mem_axi_arsize;
  logic [1:0]            m_mem_axi_arburst;
  logic                  m_mem_axi_arvalid;
  logic                  m_mem_axi_arready;
  logic                  m_mem_axi_rvalid;
  logic                  m_mem_axi_rready;
  logic                  m_mem_axi_rlast;

  modport master (
    input  s_addr_axis_tvalid, s_addr_axis_tlast, s_addr_axis_tdest,
    output s_addr_axis_tready,
    output m_fetch_axis_tvalid, m_fetch_axis_tlast, m_fetch_axis_tdest,
    input  m_fetch_axis_tready,
    output m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize,
    output m_mem_axi_arburst, m_mem_axi_arvalid,
    input  m_mem_axi_arready, m_mem_axi_rvalid, m_mem_axi_rready, m_mem_axi_rlast
  );

  modport slave (
    output s_addr_axis_tvalid, s_addr_axis_tlast, s_addr_axis_tdest,
    input  s_addr_axis_tready,
    input  m_fetch_axis_tvalid, m_fetch_axis_tlast, m_fetch_axis_tdest,
    output m_fetch_axis_tready,
    input  m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize,
    input  m_mem_axi_arburst, m_mem_axi_arvalid,
    output m_mem_axi_arready, m_mem_axi_rvalid, m_mem_axi_rready, m_mem_axi_rlast
  );
endinterface
`default_nettype wire

// File: rtl/framebuffer_fetch_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | framebuffer_fetch_requester                                                |
// | Forwards pixel indices and issues one AR per new memory line under credit. |
// | Optional FB_FETCH_REQ_STATS_EN adds stat_lines / stat_stall_cycles.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module framebuffer_fetch_requester #(
  parameter int STREAM_WIDTH    = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int PIXEL_WIDTH     = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  wire                           aclk,
  input  wire                           resetn,
  framebuffer_fetch_requester_if.master bus
`ifdef FB_FETCH_REQ_STATS_EN
  ,
  output logic [31:0]                   stat_lines,
  output logic [31:0]                   stat_stall_cycles
`endif
);
  localparam int         c_ppl        = STREAM_WIDTH / PIXEL_WIDTH;
  localparam int         c_tag_pos    = $clog2(c_ppl);
  localparam int         c_byte_shift = $clog2(STREAM_WIDTH / 8);
  localparam logic [7:0] c_max_out    = 8'(MAX_OUTSTANDING);

  logic                  r_fetch_valid;
  logic                  r_fetch_last;
  logic [ADDR_WIDTH-1:0] r_fetch_dest;
  logic                  r_ar_valid;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [ADDR_WIDTH-1:0] r_last_tag;
  logic                  r_last_tag_valid;
  logic [7:0]            r_outstanding;

  logic [ADDR_WIDTH-1:0] w_tag;
  logic [ADDR_WIDTH-1:0] w_line_addr;
  logic                  w_need_line;
  logic                  w_fetch_free;
  logic                  w_ar_free;
  logic                  w_credit;
  logic                  w_tready;
  logic                  w_accept;
  logic                  w_req;
  logic                  w_dec;

  assign w_tag        = bus.s_addr_axis_tdest >> c_tag_pos;
  assign w_line_addr  = w_tag << c_byte_shift;
  // A tag match only counts while the stored tag is live; tlast and reset clear it.
  assign w_need_line  = !r_last_tag_valid || (w_tag != r_last_tag);
  assign w_fetch_free = !r_fetch_valid || bus.m_fetch_axis_tready;
  assign w_ar_free    = !r_ar_valid || bus.m_mem_axi_arready;
  assign w_credit     = r_outstanding < c_max_out;
  assign w_tready     = resetn && w_fetch_free && (!w_need_line || (w_ar_free && w_credit));
  assign w_accept     = bus.s_addr_axis_tvalid && w_tready;
  assign w_req        = w_accept && w_need_line;
  assign w_dec        = bus.m_mem_axi_rvalid && bus.m_mem_axi_rready && bus.m_mem_axi_rlast
                        && (r_outstanding != 8'd0);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_valid    <= 1'b0;
      r_fetch_last     <= 1'b0;
      r_fetch_dest     <= '0;
      r_ar_valid       <= 1'b0;
      r_ar_addr        <= '0;
      r_last_tag       <= '0;
      r_last_tag_valid <= 1'b0;
      r_outstanding    <= 8'd0;
    end else begin
      if (w_accept) begin
        r_fetch_valid    <= 1'b1;
        r_fetch_last     <= bus.s_addr_axis_tlast;
        r_fetch_dest     <= bus.s_addr_axis_tdest;
        r_last_tag_valid <= !bus.s_addr_axis_tlast;
      end else if (bus.m_fetch_axis_tready) begin
        r_fetch_valid <= 1'b0;
      end

      if (w_req) begin
        r_ar_valid <= 1'b1;
        r_ar_addr  <= w_line_addr;
        r_last_tag <= w_tag;
      end else if (bus.m_mem_axi_arready) begin
        r_ar_valid <= 1'b0;
      end

      if (w_req && !w_dec) begin
        r_outstanding <= r_outstanding + 8'd1;
      end else if (!w_req && w_dec) begin
        r_outstanding <= r_outstanding - 8'd1;
      end
    end
  end

  assign bus.s_addr_axis_tready  = w_tready;
  assign bus.m_fetch_axis_tvalid = r_fetch_valid;
  assign bus.m_fetch_axis_tlast  = r_fetch_last;
  assign bus.m_fetch_axis_tdest  = r_fetch_dest;
  assign bus.m_mem_axi_arid      = '0;
  assign bus.m_mem_axi_araddr    = r_ar_addr;
  assign bus.m_mem_axi_arlen     = 8'd0;
  assign bus.m_mem_axi_arsize    = 3'(c_byte_shift);
  assign bus.m_mem_axi_arburst   = 2'b01;
  assign bus.m_mem_axi_arvalid   = r_ar_valid;

`ifdef FB_FETCH_REQ_STATS_EN
  logic [31:0] r_stat_lines;
  logic [31:0] r_stat_stall;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_stat_lines <= 32'd0;
      r_stat_stall <= 32'd0;
    end else begin
      if (r_ar_valid && bus.m_mem_axi_arready && (r_stat_lines != 32'hFFFF_FFFF)) begin
        r_stat_lines <= r_stat_lines + 32'd1;
      end
      if (bus.s_addr_axis_tvalid && !w_tready && (r_stat_stall != 32'hFFFF_FFFF)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_lines        = r_stat_lines;
  assign stat_stall_cycles = r_stat_stall;
`endif
endmodule
`default_nettype wire

// File: tb/tb_framebuffer_fetch_requester.sv
`default_nettype none
// Bench for framebuffer_fetch_requester: table vectors, corner sequences and a
// randomized run checked against a transaction-level line/credit model.
module tb_framebuffer_fetch_requester;
  localparam int AW   = 32;
  localparam int IDW  = 8;
  localparam int MAXO = 2;
  localparam logic [AW-1:0] PPL        = 2;
  localparam logic [AW-1:0] LINE_BYTES = 4;

  logic aclk   = 1'b0;
  logic resetn = 1'b0;
  always #5 aclk = ~aclk;

  framebuffer_fetch_requester_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IDW)) ifc ();
`ifdef FB_FETCH_REQ_STATS_EN
  logic [31:0] stat_lines;
  logic [31:0] stat_stall_cycles;
`endif

  framebuffer_fetch_requester #(
    .STREAM_WIDTH(32), .ADDR_WIDTH(AW), .ID_WIDTH(IDW),
    .PIXEL_WIDTH(16), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .aclk   (aclk),
    .resetn (resetn),
    .bus    (ifc)
`ifdef FB_FETCH_REQ_STATS_EN
    ,
    .stat_lines        (stat_lines),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  typedef struct packed { logic [AW-1:0] dest; logic last; } fetch_t;
  typedef struct packed {
    logic [AW-1:0] dest; logic last; logic exp_ar; logic [AW-1:0] exp_araddr; logic no_stall;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_t        exp_fetch[$];
  logic [AW-1:0] exp_ar[$];
  int            pend[$];
  int            inflight;
  logic [AW-1:0] last_line;
  bit            line_known;
  bit            last_acc;
  bit            resp_en;
  bit            manual_r;
  int            dmin, dmax;
  int            cyc = 0;
  int            ar_hs_count, stall_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] d);
    return (d / PPL) * LINE_BYTES;
  endfunction

  task automatic model_reset();
    exp_fetch.delete(); exp_ar.delete(); pend.delete();
    inflight = 0; last_line = '0; line_known = 0; manual_r = 0;
    ar_hs_count = 0; stall_count = 0; last_acc = 0;
  endtask

  // Observes the handshakes that will occur at the coming edge and updates the model.
  task automatic monitor();
    logic [AW-1:0] d;
    logic need, fv, fr, av, ar, exp_rdy;
    d  = ifc.s_addr_axis_tdest;
    fv = ifc.m_fetch_axis_tvalid; fr = ifc.m_fetch_axis_tready;
    av = ifc.m_mem_axi_arvalid;   ar = ifc.m_mem_axi_arready;
    need    = !line_known || ((d / PPL) != last_line);
    exp_rdy = resetn && (!fv || fr) && (!need || ((!av || ar) && (inflight < MAXO)));
    chk("s_tready", ifc.s_addr_axis_tready, exp_rdy);
    chk("fetch_valid", fv, exp_fetch.size() != 0);
    if (fv && exp_fetch.size() != 0) begin
      chk("fetch_tdest", ifc.m_fetch_axis_tdest, exp_fetch[0].dest);
      chk("fetch_tlast", ifc.m_fetch_axis_tlast, exp_fetch[0].last);
      if (fr) void'(exp_fetch.pop_front());
    end
    chk("ar_valid", av, exp_ar.size() != 0);
    if (av && exp_ar.size() != 0) begin
      chk("araddr", ifc.m_mem_axi_araddr, exp_ar[0]);
      if (ar) begin
        void'(exp_ar.pop_front());
        pend.push_back(cyc + int'($urandom_range(dmax, dmin)));
        ar_hs_count++;
      end
    end
    if (ifc.m_mem_axi_rvalid && ifc.m_mem_axi_rready && ifc.m_mem_axi_rlast) begin
      if (inflight > 0) inflight--;
      if (pend.size() > 0) void'(pend.pop_front());
    end
    if (resetn && ifc.s_addr_axis_tvalid && !exp_rdy) stall_count++;
    last_acc = ifc.s_addr_axis_tvalid && exp_rdy;
    if (last_acc) begin
      exp_fetch.push_back('{dest: d, last: ifc.s_addr_axis_tlast});
      if (need) begin
        exp_ar.push_back(line_addr(d));
        inflight++;
        last_line = d / PPL;
      end
      line_known = !ifc.s_addr_axis_tlast;
    end
  endtask

  // One clock: called at a falling edge with inputs already set.
  task automatic step();
    ifc.m_mem_axi_rvalid = (pend.size() > 0) && (manual_r || (resp_en && pend[0] <= cyc));
    ifc.m_mem_axi_rlast  = ifc.m_mem_axi_rvalid;
    #1;
    monitor();
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
  endtask

  task automatic send(input logic [AW-1:0] d, input logic last, output int waited);
    ifc.s_addr_axis_tvalid = 1'b1;
    ifc.s_addr_axis_tdest  = d;
    ifc.s_addr_axis_tlast  = last;
    waited = 0;
    do begin
      step();
      if (!last_acc) waited++;
    end while (!last_acc && waited < 50);
    if (!last_acc) chk("send_timeout", 1, 0);
    ifc.s_addr_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    ifc.s_addr_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    ifc.s_addr_axis_tvalid = 1'b0;
    resetn = 1'b0;
    model_reset();
    @(negedge aclk);
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int w;
    logic [AW-1:0] cur;

    ifc.s_addr_axis_tvalid = 0; ifc.s_addr_axis_tlast = 0; ifc.s_addr_axis_tdest = '0;
    ifc.m_fetch_axis_tready = 1; ifc.m_mem_axi_arready = 1; ifc.m_mem_axi_rready = 1;
    ifc.m_mem_axi_rvalid = 0; ifc.m_mem_axi_rlast = 0;
    resp_en = 1; dmin = 2; dmax = 2;
    model_reset();

    vecs[0] = '{32'd0, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[1] = '{32'd1, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[2] = '{32'd2, 1'b0, 1'b1, 32'h4, 1'b1};
    vecs[3] = '{32'd3, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[4] = '{32'd5, 1'b0, 1'b1, 32'h8, 1'b0};
    vecs[5] = '{32'd5, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[6] = '{32'd4, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[7] = '{32'd4, 1'b0, 1'b1, 32'h8, 1'b0};

    // Reset state
    @(negedge aclk); @(negedge aclk);
    chk("rst_s_tready", ifc.s_addr_axis_tready, 0);
    chk("rst_fetch_valid", ifc.m_fetch_axis_tvalid, 0);
    chk("rst_fetch_tdest", ifc.m_fetch_axis_tdest, 0);
    chk("rst_arvalid", ifc.m_mem_axi_arvalid, 0);
    chk("rst_araddr", ifc.m_mem_axi_araddr, 0);
    chk("arid", ifc.m_mem_axi_arid, 0);
    chk("arlen", ifc.m_mem_axi_arlen, 0);
    chk("arsize", ifc.m_mem_axi_arsize, 2);
    chk("arburst", ifc.m_mem_axi_arburst, 1);
    resetn = 1'b1;

    // Table vectors: in-line hits, new lines, tlast forcing a fresh request
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].dest, vecs[i].last, w);
      if (vecs[i].no_stall) chk("vec_no_stall", w, 0);
      chk("vec_fetch_valid", ifc.m_fetch_axis_tvalid, 1);
      chk("vec_fetch_tdest", ifc.m_fetch_axis_tdest, vecs[i].dest);
      chk("vec_fetch_tlast", ifc.m_fetch_axis_tlast, vecs[i].last);
      chk("vec_arvalid", ifc.m_mem_axi_arvalid, vecs[i].exp_ar);
      if (vecs[i].exp_ar) chk("vec_araddr", ifc.m_mem_axi_araddr, vecs[i].exp_araddr);
    end
    idle(10);

    // Credit limit: two lines in flight, third new line stalls until one retires
    do_reset();
    resp_en = 0;
    send(0, 0, w); chk("credit_first", w, 0);
    send(2, 0, w); chk("credit_second", w, 0);
    ifc.s_addr_axis_tvalid = 1; ifc.s_addr_axis_tdest = 4; ifc.s_addr_axis_tlast = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("credit_stall", ifc.s_addr_axis_tready, 0);
    end
    manual_r = 1;
    step();
    manual_r = 0;
    chk("credit_release", ifc.s_addr_axis_tready, 1);
    step();
    ifc.s_addr_axis_tvalid = 0;
    chk("credit_ar_valid", ifc.m_mem_axi_arvalid, 1);
    chk("credit_ar_addr", ifc.m_mem_axi_araddr, 32'h8);

    // AR back-pressure: address held while arready is low
    do_reset();
    resp_en = 1;
    ifc.m_mem_axi_arready = 0;
    send(8, 0, w);
    chk("arbp_valid", ifc.m_mem_axi_arvalid, 1);
    chk("arbp_addr", ifc.m_mem_axi_araddr, 32'h10);
    send(9, 0, w); chk("arbp_hit_passes", w, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("arbp_hold_valid", ifc.m_mem_axi_arvalid, 1);
      chk("arbp_hold_addr", ifc.m_mem_axi_araddr, 32'h10);
    end
    ifc.m_mem_axi_arready = 1;
    idle(1);
    chk("arbp_drop", ifc.m_mem_axi_arvalid, 0);

    // Fetch back-pressure: tdest held, input stalled, then 1/cycle
    ifc.m_fetch_axis_tready = 0;
    send(20, 0, w); chk("fbp_first", w, 0);
    ifc.s_addr_axis_tvalid = 1; ifc.s_addr_axis_tdest = 21; ifc.s_addr_axis_tlast = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fbp_stall", ifc.s_addr_axis_tready, 0);
      chk("fbp_hold_valid", ifc.m_fetch_axis_tvalid, 1);
      chk("fbp_hold_tdest", ifc.m_fetch_axis_tdest, 20);
    end
    ifc.m_fetch_axis_tready = 1;
    for (int i = 21; i < 24; i++) begin
      send(i, 0, w);
      chk("fbp_resume", w, 0);
      chk("fbp_resume_tdest", ifc.m_fetch_axis_tdest, i);
    end
    idle(10);

    // Asynchronous reset mid-stream with both outputs valid
    resp_en = 0;
    send(30, 0, w);
    idle(1);
    ifc.m_mem_axi_arready = 0; ifc.m_fetch_axis_tready = 0;
    send(32, 0, w);
    ifc.s_addr_axis_tvalid = 1; ifc.s_addr_axis_tdest = 34;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_fetch_valid", ifc.m_fetch_axis_tvalid, 0);
    chk("arst_arvalid", ifc.m_mem_axi_arvalid, 0);
    chk("arst_s_tready", ifc.s_addr_axis_tready, 0);
    chk("arst_araddr", ifc.m_mem_axi_araddr, 0);
    model_reset();
    ifc.s_addr_axis_tvalid = 0;
    @(negedge aclk);
    resetn = 1'b1;
    ifc.m_mem_axi_arready = 1; ifc.m_fetch_axis_tready = 1;
    send(1, 0, w); chk("arst_fresh_accept", w, 0);
    chk("arst_fresh_ar", ifc.m_mem_axi_arvalid, 1);
    chk("arst_fresh_addr", ifc.m_mem_axi_araddr, 32'h0);
    send(2, 0, w); chk("arst_credit_cleared", w, 0);
    ifc.s_addr_axis_tvalid = 1; ifc.s_addr_axis_tdest = 4;
    step();
    chk("arst_credit_full", ifc.s_addr_axis_tready, 0);
    ifc.s_addr_axis_tvalid = 0;

    // Randomized run against the model
    do_reset();
    resp_en = 1; dmin = 1; dmax = 6;
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!ifc.s_addr_axis_tvalid || last_acc) begin
        if ($urandom_range(3, 0) != 0) begin
          if ($urandom_range(9, 0) < 8) cur = cur + $urandom_range(2, 0);
          else cur = $urandom;
          ifc.s_addr_axis_tvalid = 1;
          ifc.s_addr_axis_tdest  = cur;
          ifc.s_addr_axis_tlast  = ($urandom_range(7, 0) == 0);
        end else begin
          ifc.s_addr_axis_tvalid = 0;
        end
      end
      ifc.m_fetch_axis_tready = ($urandom_range(3, 0) != 0);
      ifc.m_mem_axi_arready   = ($urandom_range(2, 0) != 0);
      ifc.m_mem_axi_rready    = ($urandom_range(3, 0) != 0);
      step();
    end
    ifc.m_fetch_axis_tready = 1; ifc.m_mem_axi_arready = 1; ifc.m_mem_axi_rready = 1;
    idle(40);
    chk("drain_fetch", exp_fetch.size(), 0);
    chk("drain_ar", exp_ar.size(), 0);
`ifdef FB_FETCH_REQ_STATS_EN
    chk("stat_lines", stat_lines, ar_hs_count);
    chk("stat_stall_cycles", stat_stall_cycles, stall_count);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/framebuffer_fetch_requester.md
Name: framebuffer_fetch_requester

Overview:
- Upstream neighbour of the framebuffer serializer. Consumes a stream of pixel indices from the rasterizer/readback address generator.
- For every pixel that falls in a new memory line, issues a single-beat AXI read request (AR channel). Forwards every pixel index unchanged to the serializer's fetch interface, in order.
- Throttles itself so that the number of requested-but-unreturned lines never exceeds a credit limit.

Parameters:
- STREAM_WIDTH, 32, memory data width in bits; one line = one beat
- ADDR_WIDTH, 32, width of pixel index and AXI address
- ID_WIDTH, 8, AXI ID width
- PIXEL_WIDTH, 16, pixel size in bits
- MAX_OUTSTANDING, 4, max lines in flight (1..255)

Ports:
- aclk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_addr_axis_tvalid  in  1  pixel index valid
- s_addr_axis_tready  out  1  pixel index accepted
- s_addr_axis_tlast  in  1  last pixel of a transfer
- s_addr_axis_tdest  in  ADDR_WIDTH  pixel index
- m_fetch_axis_tvalid  out  1  to serializer fetch input
- m_fetch_axis_tready  in  1
- m_fetch_axis_tlast  out  1
- m_fetch_axis_tdest  out  ADDR_WIDTH  forwarded pixel index
- m_mem_axi_arid  out  ID_WIDTH  constant 0
- m_mem_axi_araddr  out  ADDR_WIDTH  byte address of line
- m_mem_axi_arlen  out  8  constant 0
- m_mem_axi_arsize  out  3  log2(STREAM_WIDTH/8)
- m_mem_axi_arburst  out  2  constant 2'b01 (INCR)
- m_mem_axi_arvalid  out  1
- m_mem_axi_arready  in  1
- m_mem_axi_rvalid  in  1  monitor only
- m_mem_axi_rready  in  1  monitor only (serializer's rready)
- m_mem_axi_rlast  in  1  monitor only

Behaviour:
- Decided: one clock aclk; reset resetn is asynchronous, active-low. All registers clear immediately on resetn=0.
- PPL = STREAM_WIDTH/PIXEL_WIDTH. TAG_POS = log2(PPL). tag = tdest >> TAG_POS. araddr = tag << log2(STREAM_WIDTH/8); upper bits are truncated to ADDR_WIDTH.
- Reset values:
  - all tvalid/arvalid = 0; s_addr_axis_tready = 0 during reset
  - tdest/araddr = 0; outstanding counter = 0
  - lastTag = 0, lastTagValid = 0
- needLine = !lastTagValid || tag != lastTag.
- Input acceptance (combinational tready; must not depend on s_addr_axis_tvalid):
  - fetchFree = !m_fetch_axis_tvalid || m_fetch_axis_tready
  - arFree = !m_mem_axi_arvalid || m_mem_axi_arready
  - credit = outstanding < MAX_OUTSTANDING
  - tready = fetchFree && (!needLine || (arFree && credit))
- On accept (tvalid && tready), same cycle registers:
  - m_fetch_axis_{tdest,tlast} <= input; tvalid <= 1
  - if needLine: araddr <= line address; arvalid <= 1; lastTag <= tag; lastTagValid <= 1; outstanding += 1
  - if input tlast: lastTagValid <= 0, forcing a fresh request for the next transfer's first pixel
- Output retirement:
  - m_fetch_axis_tvalid drops after a handshake with no new accept.
  - arvalid drops after arready with no new request.
  - araddr/arvalid are held stable while arvalid && !arready (AXI rule); same for the fetch stream.
- Return tracking: retire = rvalid && rready && rlast, which decrements outstanding. Increment and decrement in the same cycle leave it unchanged. A decrement at 0 is ignored (saturate).
- Latency: input to fetch output and AR output is 1 cycle. Full throughput of 1 pixel/cycle while credits are available and sinks are ready.
- Ordering: the AR for a line is issued no later than the fetch entry of its first pixel, so the serializer never waits on an unrequested line.
- Boundary cases:
  - outstanding == MAX_OUTSTANDING: inputs needing a new line stall; same-line pixels still pass.
  - tag wrap: a tag compare on equal value after wrap counts as a hit only if lastTagValid.
  - Reset mid-burst drops all state; the bench must also reset the memory/serializer.

Optional Feature:
- FB_FETCH_REQ_STATS_EN.
- When defined, adds two outputs, both cleared by reset, saturating at all-ones, 32-bit:
  - stat_lines (count of AR handshakes)
  - stat_stall_cycles (cycles with s_addr_axis_tvalid && !s_addr_axis_tready)
- When undefined, these ports and counters do not exist.

Test Plan (defaults: PPL=2, line=4 bytes):
- Addresses 0,1,2,3 with tlast on 3, all sinks ready, r returns after 2 cycles -> fetch tdest 0,1,2,3 back-to-back; AR araddr 0x0 then 0x4; tlast only on 3.
- Addresses 5,5,4 -> single AR 0x8; three fetch entries; then address 4 again after tlast -> new AR 0x8.
- MAX_OUTSTANDING=2, arready=1, no R returns, addresses 0,2,4 -> ARs 0x0 and 0x4; tready held 0 at 4 until one retire (rvalid&rready&rlast), then AR 0x8 next cycle.
- arready=0 for 5 cycles after request 0x10 -> araddr stable 0x10, arvalid held; same-line follow-up pixel stalls only once the fetch register is also full.
- m_fetch_axis_tready=0 for 3 cycles -> tdest held, tready=0, no data lost; resumes at 1/cycle.
- resetn pulsed low mid-stream -> all valids 0 immediately (async); outstanding 0; first pixel after release issues a fresh AR.
